// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS32 integer core sharing one instruction/data memory port.
// Define MIPS_MC_TRAP_EN to halt on illegal instructions and misaligned accesses.
module mips_mc_core #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              halted,
  output logic [2:0]        dbg_state
);

  // Memory handshake: a transfer completes on the rising clk where
  // mem_req && mem_ready; until then mem_addr/mem_we/mem_wdata hold steady.

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

`ifdef MIPS_MC_TRAP_EN
  localparam bit     TRAP_EN  = 1'b1;
  localparam state_t BAD_NEXT = S_HALT;
`else
  localparam bit     TRAP_EN  = 1'b0;
  localparam state_t BAD_NEXT = S_FETCH;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR  = 6'h08,
                         F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                         F_OR  = 6'h25, F_SLT = 6'h2A;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, a_q, b_q, tgt_q, alu_q, alu_d, mdr_q;
  logic [31:0] regs [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] sext_imm, zext_imm, ea, j_target;
  logic        fetch_ok;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zext_imm = {16'h0000, ir_q[15:0]};
  assign ea       = a_q + sext_imm;
  assign j_target = {pc_q[31:28], ir_q[25:0], 2'b00};
  // A misaligned PC never reaches the bus in the trap build.
  assign fetch_ok = !(TRAP_EN && (pc_q[1:0] != 2'b00));

  assign pc        = pc_q;
  assign halted    = TRAP_EN && (state_q == S_HALT);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    alu_d    = alu_q;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    case (state_q)
      S_BOOT:   state_d = S_FETCH;
      S_FETCH: begin
        if (!fetch_ok) begin
          state_d = S_HALT;
        end else if (mem_ready) begin
          state_d = S_DECODE;
          pc_d    = pc_q + 32'd4;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_RTYPE: begin
            state_d = S_WB;
            case (funct)
              F_ADD: alu_d = a_q + b_q;
              F_SUB: alu_d = a_q - b_q;
              F_AND: alu_d = a_q & b_q;
              F_OR:  alu_d = a_q | b_q;
              F_SLT: alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
              F_SLL: alu_d = b_q << shamt;
              F_SRL: alu_d = b_q >> shamt;
              F_JR: begin
                pc_d    = a_q;
                state_d = S_FETCH;
              end
              default: state_d = BAD_NEXT;
            endcase
          end
          OP_ADDI: begin alu_d = a_q + sext_imm; state_d = S_WB; end
          OP_SLTI: begin alu_d = {31'd0, $signed(a_q) < $signed(sext_imm)}; state_d = S_WB; end
          OP_ANDI: begin alu_d = a_q & zext_imm; state_d = S_WB; end
          OP_ORI:  begin alu_d = a_q | zext_imm; state_d = S_WB; end
          OP_LW, OP_SW: begin
            alu_d = ea;
            if (TRAP_EN && (ea[1:0] != 2'b00)) state_d = S_HALT;
            else                               state_d = S_MEM;
          end
          OP_BEQ: if (a_q == b_q) pc_d = tgt_q;
          OP_BNE: if (a_q != b_q) pc_d = tgt_q;
          OP_J:   pc_d = j_target;
          OP_JAL: begin
            // pc_q already holds the return address (jal + 4).
            pc_d     = j_target;
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_q;
          end
          default: state_d = BAD_NEXT;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op == OP_LW) state_d = S_WB;
          else             state_d = S_FETCH;
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        rf_we    = 1'b1;
        rf_waddr = (op == OP_RTYPE) ? rd : rt;
        rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  // Bus outputs are a pure function of registered state.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (state_q == S_FETCH && fetch_ok) begin
      mem_req  = 1'b1;
      mem_addr = pc_q[ADDR_W-1:0];
    end else if (state_q == S_MEM) begin
      mem_req  = 1'b1;
      mem_addr = alu_q[ADDR_W-1:0];
      if (op == OP_SW) begin
        mem_we    = 1'b1;
        mem_wdata = b_q;
      end
    end
    if (!TRAP_EN) mem_addr[1:0] = 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ir_q  <= 32'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      tgt_q <= 32'd0;
      alu_q <= 32'd0;
      mdr_q <= 32'd0;
    end else begin
      pc_q  <= pc_d;
      alu_q <= alu_d;
      if (state_q == S_FETCH && fetch_ok && mem_ready) ir_q <= mem_rdata;
      if (state_q == S_DECODE) begin
        a_q   <= regs[rs];
        b_q   <= regs[rt];
        tgt_q <= pc_q + (sext_imm << 2);
      end
      if (state_q == S_MEM && mem_ready && op == OP_LW) mdr_q <= mem_rdata;
    end
  end

  // $0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mips_mc_core.sv
// Scoreboard bench for mips_mc_core: directed program, expected bus transactions
// (kind, we, addr, wdata, cycles since previous accept) are queued up front.
module tb_mips_mc_core;

  localparam logic [31:0] WAIT_ADDR = 32'h300;
  localparam int          WAIT_N    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [2:0]  dbg_state;

  logic [31:0] mem [0:1023];
  // {is_fetch, we, addr[31:0], wdata[31:0], delta[7:0]}
  logic [73:0] exp_q[$];
  logic [73:0] e;
  logic [31:0] cyc;
  logic [31:0] last_acc = 32'd0;
  int          wctr;
  int          loop_hits = 0;
  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b1;

  mips_mc_core #(.ADDR_W(32), .RESET_PC(32'h40)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .halted(halted), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 32'd0;
    else        cyc <= cyc + 32'd1;
  end

  // Memory model: only WAIT_ADDR inserts wait states; read data is garbage until ready.
  always @(posedge clk) begin
    if (!rst_n)                    wctr <= 0;
    else if (mem_req && mem_ready) wctr <= 0;
    else if (mem_req)              wctr <= wctr + 1;
  end
  assign mem_ready = (mem_addr != WAIT_ADDR) || (wctr >= WAIT_N);
  assign mem_rdata = mem_ready ? mem[mem_addr[11:2]] : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Encoders and driver tasks
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] tgt);
    return {op, tgt[27:2]};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[11:2]] = w;
  endtask

  task automatic exp_fetch(input logic [31:0] a, input int d);
    exp_q.push_back({1'b1, 1'b0, a, 32'd0, 8'(d)});
  endtask

  task automatic exp_data(input logic we, input logic [31:0] a, input logic [31:0] wd, input int d);
    exp_q.push_back({1'b0, we, a, wd, 8'(d)});
  endtask

  // One ALU instruction followed by a store of its destination register.
  task automatic alu_st(input logic [31:0] p, input logic [31:0] w, input logic [4:0] r,
                        input logic [31:0] v, input logic [31:0] sa, input int d);
    put(p, w);
    put(p + 32'd4, enc_i(6'h2B, 5'd0, r, sa[15:0]));
    exp_fetch(p, d);
    exp_fetch(p + 32'd4, 4);
    exp_data(1'b1, sa, v, 3);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && mon_en && mem_req) begin
      if (exp_q.size() == 0) begin
        if (mem_ready) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req: addr %h we %b with no expectation", mem_addr, mem_we);
        end
      end else if (mem_ready) begin
        e = exp_q.pop_front();
        check("acc_we", {31'd0, mem_we}, {31'd0, e[72]});
        check("acc_addr", mem_addr, e[71:40]);
        if (e[72]) check("acc_wdata", mem_wdata, e[39:8]);
        if (e[73]) check("fetch_pc", pc, e[71:40]);
        check("acc_delta", cyc - last_acc, {24'd0, e[7:0]});
        last_acc = cyc;
        if (e[73] && e[71:40] == 32'h58) loop_hits++;
      end else begin
        check("stall_addr", mem_addr, exp_q[0][71:40]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    put(32'h300, 32'hCAFE_1234);
    put(32'h004, 32'h1111_2222);

    put(32'h40, enc_i(6'h08, 5'd0, 5'd1, 16'd5));         exp_fetch(32'h40, 1);
    put(32'h44, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));      exp_fetch(32'h44, 4);
    put(32'h48, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));    exp_fetch(32'h48, 4);
    put(32'h4C, enc_i(6'h2B, 5'd0, 5'd3, 16'd8));         exp_fetch(32'h4C, 4);
    exp_data(1'b1, 32'h8, 32'd2, 3);
    put(32'h50, enc_i(6'h23, 5'd0, 5'd4, 16'h300));       exp_fetch(32'h50, 1);
    exp_data(1'b0, 32'h300, 32'd0, 3 + WAIT_N);
    put(32'h54, enc_i(6'h2B, 5'd0, 5'd4, 16'd12));        exp_fetch(32'h54, 2);
    exp_data(1'b1, 32'hC, 32'hCAFE_1234, 3);
    put(32'h58, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF));      exp_fetch(32'h58, 1);
    exp_fetch(32'h58, 3);
    exp_fetch(32'h58, 3);                                  // patched to bne
    put(32'h5C, enc_j(6'h02, 32'h100));                   exp_fetch(32'h5C, 3);
    put(32'h100, enc_j(6'h03, 32'h200));                  exp_fetch(32'h100, 3);
    put(32'h200, enc_i(6'h08, 5'd0, 5'd0, 16'd7));        exp_fetch(32'h200, 3);
    put(32'h204, enc_i(6'h2B, 5'd0, 5'd0, 16'd16));       exp_fetch(32'h204, 4);
    exp_data(1'b1, 32'h10, 32'd0, 3);
    put(32'h208, enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));  exp_fetch(32'h208, 1);
    put(32'h104, enc_i(6'h2B, 5'd0, 5'd31, 16'd20));      exp_fetch(32'h104, 3);
    exp_data(1'b1, 32'h14, 32'h104, 3);
    put(32'h108, 32'hFC00_0000);                          exp_fetch(32'h108, 1);
`ifndef MIPS_MC_TRAP_EN
    alu_st(32'h10C, enc_i(6'h0D, 5'd0, 5'd5, 16'hF0F0),   5'd5,  32'h0000_F0F0, 32'h800, 3);
    alu_st(32'h114, enc_i(6'h0C, 5'd2, 5'd6, 16'hFF00),   5'd6,  32'h0000_FF00, 32'h804, 1);
    alu_st(32'h11C, enc_r(5'd2, 5'd1, 5'd7, 5'd0, 6'h2A), 5'd7,  32'd1,         32'h808, 1);
    alu_st(32'h124, enc_i(6'h0A, 5'd2, 5'd8, 16'hFFFE),   5'd8,  32'd1,         32'h80C, 1);
    alu_st(32'h12C, enc_r(5'd0, 5'd1, 5'd9, 5'd4, 6'h00), 5'd9,  32'h50,        32'h810, 1);
    alu_st(32'h134, enc_r(5'd0, 5'd2, 5'd10, 5'd28, 6'h02), 5'd10, 32'hF,       32'h814, 1);
    alu_st(32'h13C, enc_r(5'd1, 5'd2, 5'd11, 5'd0, 6'h22), 5'd11, 32'd8,        32'h818, 1);
    alu_st(32'h144, enc_r(5'd5, 5'd6, 5'd12, 5'd0, 6'h24), 5'd12, 32'hF000,     32'h81C, 1);
    alu_st(32'h14C, enc_r(5'd7, 5'd9, 5'd13, 5'd0, 6'h25), 5'd13, 32'h51,       32'h820, 1);
    alu_st(32'h154, enc_i(6'h0A, 5'd1, 5'd15, 16'hFFFF),  5'd15, 32'd0,         32'h828, 1);
    put(32'h15C, enc_i(6'h23, 5'd0, 5'd14, 16'd6));       exp_fetch(32'h15C, 1);
    exp_data(1'b0, 32'h4, 32'd0, 3);
    put(32'h160, enc_i(6'h2B, 5'd0, 5'd14, 16'h824));     exp_fetch(32'h160, 2);
    exp_data(1'b1, 32'h824, 32'h1111_2222, 3);
    put(32'h164, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));     exp_fetch(32'h164, 1);
    exp_fetch(32'h164, 3);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_pc", pc, 32'h40);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("boot_no_req", {31'd0, mem_req}, 32'd0);

    // Break the beq self-loop after its second fetch has been accepted.
    for (int i = 0; i < 500 && loop_hits < 2; i++) @(posedge clk);
    if (loop_hits < 2) begin
      checks++;
      failures++;
      $display("FAIL loop_timeout: hits %0d want 2", loop_hits);
    end
    #1;
    put(32'h58, enc_i(6'h05, 5'd1, 5'd1, 16'hFFFF));

    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d transactions outstanding, want 0", exp_q.size());
    end
`ifdef MIPS_MC_TRAP_EN
    repeat (10) @(posedge clk);
    #1;
    check("trap_halted", {31'd0, halted}, 32'd1);
    check("trap_no_req", {31'd0, mem_req}, 32'd0);
`else
    mon_en = 1'b0;
    check("end_halted", {31'd0, halted}, 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
